// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter for the single register-bank write port
// Optional power-up clear sweep enabled by defining REGARB_INIT_CLEAR_EN.
module regbank_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rb_we,
  output logic [ADDR_W-1:0] rb_waddr,
  output logic [DATA_W-1:0] rb_wdata,
  output logic              busy
);

  logic              run;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

`ifdef REGARB_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic              sweep_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_INIT);
      // Counter parks on the last register rather than wrapping.
      if (state == ST_INIT && !sweep_last)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    sweep_last = &cnt;
    if (state == ST_INIT && sweep_last)
      state_next = ST_RUN;
  end

  assign run = (state == ST_RUN);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // On a tie the port that did not win the previous transfer is served.
  assign grant0 = run && req0_valid && (!req1_valid || last_grant);
  assign grant1 = run && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req0_addr;
    wr_data = req0_data;
    if (grant0) begin
      wr_en = 1'b1;
    end else if (grant1) begin
      wr_en   = 1'b1;
      wr_addr = req1_addr;
      wr_data = req1_data;
    end
`ifdef REGARB_INIT_CLEAR_EN
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rb_we      <= 1'b0;
      rb_waddr   <= '0;
      rb_wdata   <= '0;
      last_grant <= 1'b1;
    end else begin
      rb_we <= wr_en;
      if (wr_en) begin
        rb_waddr <= wr_addr;
        rb_wdata <= wr_data;
      end
      if (grant0)
        last_grant <= 1'b0;
      else if (grant1)
        last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - directed self-checking bench for regbank_write_arbiter
// Covers the REGARB_INIT_CLEAR_EN sweep when that macro is defined for the build.
module tb_regbank_write_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;

`ifdef REGARB_INIT_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rb_we;
  logic [ADDR_W-1:0] rb_waddr;
  logic [DATA_W-1:0] rb_wdata;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  regbank_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rb_we      (rb_we),
    .rb_waddr   (rb_waddr),
    .rb_wdata   (rb_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
`ifdef REGARB_INIT_CLEAR_EN
    repeat (64) step();
`endif
  endtask

  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1;
  int                exp_g;

  initial begin
    reset      = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    step();
    step();
    check("rst_we", rb_we, 0);
    check("rst_waddr", rb_waddr, 0);
    check("rst_wdata", rb_wdata, 0);
    check("rst_busy", busy, BUSY_RST);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

`ifdef REGARB_INIT_CLEAR_EN
    // Sweep with both requesters pending: no grants until the sweep ends.
    req0_valid = 1'b1; req0_addr = 6'd3; req0_data = 64'h33;
    req1_valid = 1'b1; req1_addr = 6'd4; req1_data = 64'h44;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      check($sformatf("sweep_ready0_%0d", i), req0_ready, 0);
      check($sformatf("sweep_ready1_%0d", i), req1_ready, 0);
      step();
      check($sformatf("sweep_we_%0d", i), rb_we, 1);
      check($sformatf("sweep_addr_%0d", i), rb_waddr, i);
      check($sformatf("sweep_data_%0d", i), rb_wdata, 0);
      check($sformatf("sweep_busy_%0d", i), busy, (i != 63));
    end
    #1;
    check("post_sweep_ready0", req0_ready, 1);
    check("post_sweep_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (21) step();
    check("mid_sweep_addr20", rb_waddr, 20);
    reset = 1'b0;
    step();
    check("mid_rst_we", rb_we, 0);
    check("mid_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    check("restart_we", rb_we, 1);
    check("restart_addr0", rb_waddr, 0);
    step();
    check("restart_addr1", rb_waddr, 1);
    for (int k = 0; k < 100 && busy; k++) step();
    check("restart_done_busy", busy, 0);
    check("restart_last_addr", rb_waddr, 63);
`else
    // Valid held from reset release: ready in the very first cycle.
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 6'd7; req0_data = 64'h77;
    #1;
    check("first_ready0", req0_ready, 1);
    check("first_ready1", req1_ready, 0);
    check("first_busy", busy, 0);
    step();
    check("first_we", rb_we, 1);
    check("first_addr", rb_waddr, 7);
    check("first_data", rb_wdata, 64'h77);
    req0_valid = 1'b0;
    step();
    check("first_idle_we", rb_we, 0);
    check("first_idle_busy", busy, 0);
`endif

    // Single requester.
    reset_dut();
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 64'hA5;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    step();
    check("single_we", rb_we, 1);
    check("single_addr", rb_waddr, 5);
    check("single_data", rb_wdata, 64'hA5);
    req0_valid = 1'b0;
    #1;
    check("single_idle_ready0", req0_ready, 0);
    step();
    check("single_idle_we", rb_we, 0);
    check("single_hold_addr", rb_waddr, 5);
    check("single_hold_data", rb_wdata, 64'hA5);

    // Contention from reset: grants alternate 0,1,0,1.
    reset_dut();
    a0 = 6'd1; d0 = 64'h10;
    a1 = 6'd2; d1 = 64'h20;
    req0_valid = 1'b1; req0_addr = a0; req0_data = d0;
    req1_valid = 1'b1; req1_addr = a1; req1_data = d1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i % 2;
      #1;
      check($sformatf("cont_ready0_%0d", i), req0_ready, (exp_g == 0));
      check($sformatf("cont_ready1_%0d", i), req1_ready, (exp_g == 1));
      step();
      check($sformatf("cont_we_%0d", i), rb_we, 1);
      check($sformatf("cont_addr_%0d", i), rb_waddr, (exp_g == 0) ? a0 : a1);
      check($sformatf("cont_data_%0d", i), rb_wdata, (exp_g == 0) ? d0 : d1);
      if (exp_g == 0) begin
        a0 = a0 + 6'd2; d0 = d0 + 64'd1;
        req0_addr = a0; req0_data = d0;
      end else begin
        a1 = a1 + 6'd2; d1 = d1 + 64'd1;
        req1_addr = a1; req1_data = d1;
      end
    end

    // Same address: last grant was port 1, so port 0 goes first.
    req0_addr = 6'd9; req0_data = 64'd1;
    req1_addr = 6'd9; req1_data = 64'd2;
    #1;
    check("same_ready0", req0_ready, 1);
    check("same_ready1", req1_ready, 0);
    step();
    check("same_we_a", rb_we, 1);
    check("same_addr_a", rb_waddr, 9);
    check("same_data_a", rb_wdata, 1);
    req0_valid = 1'b0;
    #1;
    check("same_ready1_b", req1_ready, 1);
    step();
    check("same_we_b", rb_we, 1);
    check("same_addr_b", rb_waddr, 9);
    check("same_data_b", rb_wdata, 2);
    req1_valid = 1'b0;
    step();
    check("same_idle_we", rb_we, 0);
    check("same_hold_data", rb_wdata, 2);

    // Lone requester 1 streams with ready held high.
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_addr = 6'(30 + i);
      req1_data = 64'hC0 + 64'(i);
      #1;
      check($sformatf("stream_ready1_%0d", i), req1_ready, 1);
      step();
      check($sformatf("stream_we_%0d", i), rb_we, 1);
      check($sformatf("stream_addr_%0d", i), rb_waddr, 30 + i);
      check($sformatf("stream_data_%0d", i), rb_wdata, 64'hC0 + 64'(i));
    end
    req1_valid = 1'b0;

    // Reset in RUN drops a pending write and restores the port-0 tie preference.
    req0_valid = 1'b1; req0_addr = 6'd12; req0_data = 64'hEE;
    reset = 1'b0;
    step();
    check("rundrop_we", rb_we, 0);
    check("rundrop_addr", rb_waddr, 0);
    req0_valid = 1'b0;
    reset_dut();
    req0_valid = 1'b1; req0_addr = 6'd13; req0_data = 64'h13;
    req1_valid = 1'b1; req1_addr = 6'd14; req1_data = 64'h14;
    #1;
    check("tie_after_rst_ready0", req0_ready, 1);
    check("tie_after_rst_ready1", req1_ready, 0);
    step();
    check("tie_after_rst_addr", rb_waddr, 13);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
